// File: rtl/bist_pattern_ctrl.sv
// rtl/bist_pattern_ctrl.sv - LFSR pattern generator and MISR signature checker for cell-array BIST
`timescale 1ns/1ps
module bist_pattern_ctrl #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
    parameter logic [WIDTH-1:0] SEED   = 8'h01,
    parameter int               NPAT   = 255,
    parameter logic [WIDTH-1:0] GOLDEN = 8'h00
) (
    input  logic             CK,
    input  logic             R,
    input  logic             START,
    input  logic [WIDTH-1:0] RESP,
    output logic [WIDTH-1:0] PAT,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SIG,
    output logic             PASS
);

    // Counter holds 1..NPAT while running; sized so NPAT itself never wraps.
    localparam int CW = $clog2(NPAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] pat_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    // Shift left, feedback bit is the parity of the tapped bits.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ^(v & TAPS)};
    endfunction

    assign lfsr_d = lfsr_step(lfsr_q);
    assign sig_d  = lfsr_step(sig_q) ^ RESP;

    // Sequencer: lfsr_q is the pattern currently on PAT while running; the
    // MISR lags one cycle behind because the array returns RESP a cycle late.
    always_ff @(posedge CK or negedge R) begin
        if (!R) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            sig_q   <= '0;
            cnt_q   <= '0;
            pat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        state_q <= S_RUN;
                        lfsr_q  <= SEED;
                        sig_q   <= '0;
                        cnt_q   <= CW'(1);
                        pat_q   <= SEED;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    // First RUN cycle has no response yet: the array is still filling.
                    if (cnt_q != CW'(1)) begin
                        sig_q <= sig_d;
                    end
                    if (cnt_q == CW'(NPAT)) begin
                        state_q <= S_DRAIN;
                        pat_q   <= '0;
                    end else begin
                        lfsr_q <= lfsr_d;
                        pat_q  <= lfsr_d;
                        cnt_q  <= cnt_q + CW'(1);
                    end
                end
                S_DRAIN: begin
                    // Response to the last pattern arrives here.
                    sig_q   <= sig_d;
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (sig_d == GOLDEN);
                end
                default: begin
                    state_q <= S_IDLE;
                    pat_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign PAT  = pat_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign SIG  = sig_q;
    assign PASS = pass_q;

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// tb/tb_bist_pattern_ctrl.sv - self-checking bench for bist_pattern_ctrl
`timescale 1ns/1ps
module tb_bist_pattern_ctrl;

    logic       CK = 1'b0;
    logic       R = 1'b0;
    logic       START = 1'b0;
    logic [7:0] RESP = 8'h00;

    logic [7:0] pat_w  [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic [7:0] sig_w  [3];
    logic       pass_w [3];

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 CK = ~CK;

    // Instance 0: defaults. Instances 1/2: four patterns, golden 05 and 00.
    bist_pattern_ctrl u_def (
        .CK(CK), .R(R), .START(START), .RESP(RESP),
        .PAT(pat_w[0]), .BUSY(busy_w[0]), .DONE(done_w[0]), .SIG(sig_w[0]), .PASS(pass_w[0])
    );
    bist_pattern_ctrl #(.NPAT(4), .GOLDEN(8'h05)) u_n4p (
        .CK(CK), .R(R), .START(START), .RESP(RESP),
        .PAT(pat_w[1]), .BUSY(busy_w[1]), .DONE(done_w[1]), .SIG(sig_w[1]), .PASS(pass_w[1])
    );
    bist_pattern_ctrl #(.NPAT(4), .GOLDEN(8'h00)) u_n4f (
        .CK(CK), .R(R), .START(START), .RESP(RESP),
        .PAT(pat_w[2]), .BUSY(busy_w[2]), .DONE(done_w[2]), .SIG(sig_w[2]), .PASS(pass_w[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] mstep(input logic [7:0] s, input logic [7:0] r);
        return {s[6:0], ^(s & 8'hB8)} ^ r;
    endfunction

    function automatic logic [7:0] resp_fn(input int k);
        return 8'(k * 29 + 7);
    endfunction

    // Behavioural model: pos = cycle number within the run (1..npat RUN, npat+1 DRAIN), 0 = not running.
    logic [7:0] pat_tab [1:256];
    int         npat_m [3] = '{255, 4, 4};
    logic [7:0] gold_m [3] = '{8'h00, 8'h05, 8'h00};
    int         pos_m  [3] = '{0, 0, 0};
    bit         done_m [3] = '{0, 0, 0};
    logic [7:0] sig_m  [3] = '{8'h00, 8'h00, 8'h00};

    always @(posedge CK or negedge R) begin
        for (int i = 0; i < 3; i++) begin
            if (!R) begin
                pos_m[i] = 0; done_m[i] = 1'b0; sig_m[i] = 8'h00;
            end else if (pos_m[i] != 0) begin
                if (pos_m[i] >= 2) sig_m[i] = mstep(sig_m[i], RESP);
                if (pos_m[i] == npat_m[i] + 1) begin
                    pos_m[i] = 0; done_m[i] = 1'b1;
                end else begin
                    pos_m[i]++;
                end
            end else if (START) begin
                pos_m[i] = 1; sig_m[i] = 8'h00; done_m[i] = 1'b0;
            end
        end
    end

    // Every-cycle comparison of all instances against the model, away from the active edge.
    always @(negedge CK) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic [7:0] ep;
                ep = (pos_m[i] >= 1 && pos_m[i] <= npat_m[i]) ? pat_tab[pos_m[i]] : 8'h00;
                chk($sformatf("pat%0d", i),  pat_w[i],  ep);
                chk($sformatf("busy%0d", i), busy_w[i], (pos_m[i] != 0));
                chk($sformatf("done%0d", i), done_w[i], done_m[i]);
                chk($sformatf("sig%0d", i),  sig_w[i],  sig_m[i]);
                chk($sformatf("pass%0d", i), pass_w[i], done_m[i] && (sig_m[i] == gold_m[i]));
            end
        end
    end

    task automatic tick();
        @(posedge CK);
        #2;
    endtask

    // Start a default-instance run and follow it to DONE, driving RESP from the run cycle index.
    task automatic run_def(input bit hold, output logic [7:0] sig_out, output int busy_cnt);
        int k;
        START = 1'b1;
        tick();
        START = hold;
        k = 1;
        busy_cnt = 0;
        while (!done_w[0] && k < 400) begin
            RESP = resp_fn(k);
            if (busy_w[0]) busy_cnt++;
            if (k <= 4) chk($sformatf("rerun_pat%0d", k), pat_w[0], pat_tab[k]);
            tick();
            k++;
        end
        chk("run_def_reached_done", done_w[0], 1'b1);
        sig_out = sig_w[0];
    endtask

    logic [7:0] obs [1:300];
    logic [7:0] s1, s2, s3;
    int         bc, n;
    logic [7:0] v;

    initial begin
        v = 8'h01;
        for (int i = 1; i <= 256; i++) begin
            pat_tab[i] = v;
            v = {v[6:0], ^(v & 8'hB8)};
        end
        chk("model_pat1", pat_tab[1], 8'h01);
        chk("model_pat5", pat_tab[5], 8'h11);
        chk("model_pat255", pat_tab[255], 8'h80);
        chk("model_wrap", pat_tab[256], 8'h01);

        // Reset held with START high and noisy RESP.
        R = 1'b0; START = 1'b1; RESP = 8'($urandom);
        tick();
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin RESP = 8'($urandom); tick(); end
        chk("rst_pat", pat_w[0], 8'h00);
        chk("rst_busy", busy_w[0], 1'b0);
        chk("rst_done", done_w[0], 1'b0);
        chk("rst_sig", sig_w[0], 8'h00);
        chk("rst_pass", pass_w[0], 1'b0);

        // Release reset; RUN begins at the next edge. AA during the first RUN cycle must be ignored.
        RESP = 8'hAA; R = 1'b1;
        tick();
        chk("rel_busy", busy_w[0], 1'b1);
        chk("rel_pat", pat_w[0], 8'h01);
        START = 1'b0;
        bc = 0; n = 0;
        while (busy_w[0] && n < 400) begin
            bc++;
            if (bc <= 300) obs[bc] = pat_w[0];
            tick();
            if (bc == 1) RESP = 8'h00;
            n++;
        end
        chk("busy_len", bc, 256);
        chk("seq1", obs[1], 8'h01);
        chk("seq2", obs[2], 8'h02);
        chk("seq3", obs[3], 8'h04);
        chk("seq4", obs[4], 8'h08);
        chk("seq5", obs[5], 8'h11);
        chk("seq255", obs[255], 8'h80);
        chk("drain_pat", obs[256], 8'h00);
        chk("zero_done", done_w[0], 1'b1);
        chk("zero_sig", sig_w[0], 8'h00);
        chk("zero_pass", pass_w[0], 1'b1);
        chk("n4f_zero_pass", pass_w[2], 1'b1);
        chk("n4p_zero_pass", pass_w[1], 1'b0);

        // Signature with RESP tied FF on the four-pattern instances.
        RESP = 8'hFF; START = 1'b1;
        tick();
        START = 1'b0;
        tick(); chk("n4_sig_e1", sig_w[1], 8'h00);
        tick(); chk("n4_sig_e2", sig_w[1], 8'hFF);
        tick(); chk("n4_sig_e3", sig_w[1], 8'h01);
        tick(); chk("n4_sig_e4", sig_w[1], 8'hFD);
        chk("n4_not_done_yet", done_w[1], 1'b0);
        tick();
        chk("n4_sig_done", sig_w[1], 8'h05);
        chk("n4_done", done_w[1], 1'b1);
        chk("n4_pass_g05", pass_w[1], 1'b1);
        chk("n4_pass_g00", pass_w[2], 1'b0);
        chk("n4_sig_g00", sig_w[2], 8'h05);
        n = 0;
        while (!done_w[0] && n < 400) begin tick(); n++; end
        chk("ff_def_done", done_w[0], 1'b1);

        // Reset during RUN cycle 10.
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 1; k <= 9; k++) begin RESP = resp_fn(k); tick(); end
        RESP = resp_fn(10);
        R = 1'b0;
        #1;
        chk("async_busy", busy_w[0], 1'b0);
        chk("async_pat", pat_w[0], 8'h00);
        chk("async_sig", sig_w[0], 8'h00);
        tick();
        R = 1'b1;

        run_def(1'b0, s1, bc);
        chk("full_busy_len", bc, 256);
        // START held through the run and into DONE: no extension, then an identical rerun.
        run_def(1'b1, s2, bc);
        chk("hold_busy_len", bc, 256);
        chk("hold_sig_same", s2, s1);
        run_def(1'b1, s3, bc);
        chk("restart_sig_same", s3, s1);
        START = 1'b0;
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bist_pattern_ctrl.md
Name: bist_pattern_ctrl

Overview:
- Built-in self-test controller for standard-cell test structures. A Fibonacci LFSR generates pseudo-random patterns onto PAT, which drives a cell-under-test (gate/flop array).
- The block compacts the returned responses in a MISR and compares the final signature against a golden value.
- It sits directly upstream and downstream of the cell array. The array is expected to register its output with one flop stage, so RESP is sampled one cycle after the matching PAT.

Parameters:
- WIDTH, 8, pattern/response/signature width (>=2).
- TAPS, 8'hB8, feedback mask (bit i set = bit i in feedback XOR). Default is maximal-length for WIDTH=8.
- SEED, 8'h01, LFSR start value. Must be non-zero.
- NPAT, 255, number of patterns applied per run (1..2^WIDTH-1).
- GOLDEN, 8'h00, expected final signature.

Ports:
- CK  input  1  clock, rising edge.
- R  input  1  reset, asynchronous, active-low.
- START  input  1  run request, level-sampled.
- RESP  input  WIDTH  response from cell array, sampled on CK.
- PAT  output  WIDTH  pattern to cell array.
- BUSY  output  1  high in RUN and DRAIN.
- DONE  output  1  high in DONE state.
- SIG  output  WIDTH  current MISR signature.
- PASS  output  1  SIG==GOLDEN, qualified by DONE.

Behaviour:
- One clock; reset is asynchronous and active-low. R=0 immediately forces:
  - state IDLE;
  - LFSR=SEED, MISR=0, pattern counter=0;
  - PAT=0, BUSY=0, DONE=0, SIG=0, PASS=0.
  - Reset mid-run aborts with no partial result retained.
- All outputs are registered. PAT=0 in every state except RUN.
- LFSR step: lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
- MISR step: sig_next = {sig[WIDTH-2:0], ^(sig & TAPS)} ^ RESP.
- States:
  - IDLE: START=1 at an edge -> RUN; load LFSR=SEED, MISR=0, counter=0.
  - RUN: PAT=current LFSR; LFSR advances each cycle; counter increments.
    - MISR captures RESP on every RUN cycle except the first; the first RUN cycle's RESP is ignored (pipeline fill).
    - After NPAT RUN cycles -> DRAIN.
  - DRAIN: one cycle; MISR captures the response to the final pattern; PAT=0 -> DONE.
  - DONE: DONE=1, SIG frozen, PASS=(SIG==GOLDEN).
    - Held until START=1 is sampled, which restarts exactly as from IDLE (MISR cleared, LFSR=SEED).
- START is ignored in RUN and DRAIN; no restart or extension.
- Latency for START sampled at edge 0:
  - RUN occupies cycles 1..NPAT;
  - DRAIN is cycle NPAT+1;
  - DONE/PASS valid from cycle NPAT+2.
- Total MISR captures per run = NPAT.
- The counter is wide enough for NPAT; no wrap within a run. The LFSR returns to SEED after 2^WIDTH-1 steps (maximal TAPS).
- SIG output mirrors the MISR register at all times and is meaningful only when DONE=1.

Test Plan:
- Reset: hold R=0 with START=1 and random RESP -> all outputs 0, state IDLE. Release R -> RUN starts the following edge (START still 1).
- Pattern sequence, defaults: START pulse -> PAT = 01,02,04,08,11,... on consecutive RUN cycles. The 255th pattern = 8'h80, then PAT=0 in DRAIN. BUSY is high for exactly 256 cycles.
- Signature, NPAT=4, RESP tied 8'hFF -> SIG progression FF,01,FD,05. DONE at cycle 6 with SIG=8'h05; PASS=1 with GOLDEN=8'h05, PASS=0 with GOLDEN=8'h00.
- Zero response: RESP=0, defaults -> SIG=00, PASS=1 with GOLDEN=00. First-cycle RESP glitch of 8'hAA is ignored (SIG still 00).
- Reset mid-run: assert R=0 at RUN cycle 10 -> outputs clear asynchronously. A following START produces a full, identical 01,02,04... sequence and the same final SIG as an uninterrupted run.
- Restart and ignore: START held high through RUN -> no effect until DONE. START in DONE -> new run with MISR cleared, reproducing identical SIG.
